// File: rtl/de_bruijn_mux_n.sv
// N-channel registered input-merge mux for a de Bruijn routing node.
// Fixed-select or round-robin grant feeding a one-entry valid/ready output register.
module de_bruijn_mux_n #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam logic [SEL_W:0] NCH = CHANNELS[SEL_W:0];

  logic                 vld_p1;
  logic [WIDTH-1:0]     data_p1;
  logic [SEL_W-1:0]     chan_p1;
  logic [SEL_W-1:0]     ptr_p1;

  logic                 gnt_vld_p0;
  logic [SEL_W-1:0]     gnt_idx_p0;
  logic [WIDTH-1:0]     gnt_data_p0;
  logic [SEL_W-1:0]     ptr_nxt_p0;
  logic [SEL_W:0]       scan_p0;
  logic                 load_ok_p0;
  logic                 xfer_p0;

  // Stage p0: grant selection, combinational from the inputs and the held state
  always_comb begin
    gnt_vld_p0 = 1'b0;
    gnt_idx_p0 = '0;
    scan_p0    = '0;
    if (!mode) begin
      // An out-of-range select matches no channel and so yields no grant.
      for (int i = 0; i < CHANNELS; i++) begin
        if (sel == i[SEL_W-1:0] && in_valid[i]) begin
          gnt_vld_p0 = 1'b1;
          gnt_idx_p0 = i[SEL_W-1:0];
        end
      end
    end else begin
      // Scan offsets from farthest to nearest so the nearest valid channel to ptr wins.
      for (int k = CHANNELS - 1; k >= 0; k--) begin
        scan_p0 = {1'b0, ptr_p1} + k[SEL_W:0];
        if (scan_p0 >= NCH) scan_p0 = scan_p0 - NCH;
        for (int i = 0; i < CHANNELS; i++) begin
          if (scan_p0 == i[SEL_W:0] && in_valid[i]) begin
            gnt_vld_p0 = 1'b1;
            gnt_idx_p0 = i[SEL_W-1:0];
          end
        end
      end
    end
  end

  always_comb begin
    gnt_data_p0 = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (gnt_idx_p0 == i[SEL_W-1:0]) gnt_data_p0 = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    load_ok_p0 = !vld_p1 || out_ready;
    xfer_p0    = gnt_vld_p0 && load_ok_p0 && !rst;
    for (int i = 0; i < CHANNELS; i++) begin
      in_ready[i] = xfer_p0 && (gnt_idx_p0 == i[SEL_W-1:0]);
    end
    if ({1'b0, gnt_idx_p0} == NCH - 1'b1) ptr_nxt_p0 = '0;
    else                                  ptr_nxt_p0 = gnt_idx_p0 + 1'b1;
  end

  // Stage p1: one-entry output register and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      chan_p1 <= '0;
      ptr_p1  <= '0;
    end else if (xfer_p0) begin
      vld_p1  <= 1'b1;
      data_p1 <= gnt_data_p0;
      chan_p1 <= gnt_idx_p0;
      if (mode) ptr_p1 <= ptr_nxt_p0;
    end else if (out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_chan  = chan_p1;

endmodule
